// File: rtl/axis_s_rx_pkg.sv
// Shared types and default widths for the AXI-Stream slave receiver.
// Optional packet counter is enabled with AXIS_RX_PKT_CNT_EN.
package axis_rx_pkg;

  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned TDATA_W_DEF = 32;
  localparam int unsigned TUSER_W_DEF = 2;
  localparam int unsigned PKT_CNT_W   = 16;

  typedef struct packed {
    logic [TDATA_W_DEF-1:0]   tdata;
    logic [TDATA_W_DEF/8-1:0] tstrb;
    logic [TDATA_W_DEF/8-1:0] tkeep;
    logic [TUSER_W_DEF-1:0]   tuser;
    logic                     tlast;
  } axis_beat_t;

endpackage

// File: rtl/axis_s_rx_if.sv
// Bundles the upstream AXI-Stream and backend valid/ready signals of axis_s_rx.
// pkt_cnt exists only when AXIS_RX_PKT_CNT_EN is defined.
interface axis_s_rx_if
  import axis_rx_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TDATA_W = TDATA_W_DEF,
  parameter int unsigned TUSER_W = TUSER_W_DEF
) ();

  localparam int unsigned KeepW = TDATA_W / 8;
  localparam int unsigned LvlW  = $clog2(DEPTH) + 1;

  logic               axis_tvalid;
  logic [TDATA_W-1:0] axis_tdata;
  logic [KeepW-1:0]   axis_tstrb;
  logic [KeepW-1:0]   axis_tkeep;
  logic               axis_tlast;
  logic [TUSER_W-1:0] axis_tuser;
  logic               axis_tready;

  logic [TDATA_W-1:0] bk_data;
  logic [KeepW-1:0]   bk_tstrb;
  logic [KeepW-1:0]   bk_tkeep;
  logic [TUSER_W-1:0] bk_user;
  logic               bk_tlast;
  logic               bk_valid;
  logic               bk_ready;

  logic [LvlW-1:0]    fifo_level;
`ifdef AXIS_RX_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] pkt_cnt;
`endif

  // Receiver side.
  modport slave (
    input  axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser,
    output axis_tready,
    output bk_data, bk_tstrb, bk_tkeep, bk_user, bk_tlast, bk_valid,
    input  bk_ready,
    output fifo_level
`ifdef AXIS_RX_PKT_CNT_EN
    , output pkt_cnt
`endif
  );

  // Upstream source plus backend consumer side.
  modport master (
    output axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast, axis_tuser,
    input  axis_tready,
    input  bk_data, bk_tstrb, bk_tkeep, bk_user, bk_tlast, bk_valid,
    output bk_ready,
    input  fifo_level
`ifdef AXIS_RX_PKT_CNT_EN
    , input pkt_cnt
`endif
  );

endinterface

// File: rtl/axis_s_rx_fifo.sv
// First-word-fall-through synchronous FIFO of stream beats; head output holds
// the last popped beat while empty.
module axis_rx_fifo
  import axis_rx_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter type         beat_t = axis_beat_t
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  beat_t                wdata_i,
  output logic                 full_o,
  input  logic                 pop_i,
  output beat_t                rdata_o,
  output logic                 empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [LvlW-1:0] LvlFull = LvlW'(DEPTH);

  beat_t           mem_q [DEPTH];
  beat_t           last_q, last_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            do_push, do_pop;

  assign full_o  = (level_q == LvlFull);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = empty_o ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    last_d   = last_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    if (do_push && !do_pop) level_d = level_q + 1'b1;
    else if (do_pop && !do_push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: rtl/axis_s_rx.sv
// AXI-Stream slave receiver: buffers beats in a FWFT FIFO, drops null beats and,
// with AXIS_RX_PKT_CNT_EN defined, counts packets on accepted tlast beats.
module axis_s_rx
  import axis_rx_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TDATA_W = TDATA_W_DEF,
  parameter int unsigned TUSER_W = TUSER_W_DEF
) (
  input  logic       axi_aclk,
  input  logic       axi_aresetn,
  axis_s_rx_if.slave rx_io
);

  localparam int unsigned KeepW = TDATA_W / 8;

  typedef struct packed {
    logic [TDATA_W-1:0] tdata;
    logic [KeepW-1:0]   tstrb;
    logic [KeepW-1:0]   tkeep;
    logic [TUSER_W-1:0] tuser;
    logic               tlast;
  } beat_t;

  beat_t wr_beat, rd_beat;
  logic  live_q;
  logic  full, empty, accept, push, pop;

  // Holds tready low until the first edge after reset release.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) live_q <= 1'b0;
    else              live_q <= 1'b1;
  end

  assign rx_io.axis_tready = live_q && !full;
  assign accept = rx_io.axis_tvalid && rx_io.axis_tready;
  assign push   = accept && (rx_io.axis_tkeep != '0);
  assign pop    = rx_io.bk_valid && rx_io.bk_ready;

  assign wr_beat = '{
    tdata: rx_io.axis_tdata,
    tstrb: rx_io.axis_tstrb,
    tkeep: rx_io.axis_tkeep,
    tuser: rx_io.axis_tuser,
    tlast: rx_io.axis_tlast
  };

  axis_rx_fifo #(
    .DEPTH  (DEPTH),
    .beat_t (beat_t)
  ) u_fifo (
    .clk_i   (axi_aclk),
    .rst_ni  (axi_aresetn),
    .push_i  (push),
    .wdata_i (wr_beat),
    .full_o  (full),
    .pop_i   (pop),
    .rdata_o (rd_beat),
    .empty_o (empty),
    .level_o (rx_io.fifo_level)
  );

  assign rx_io.bk_valid = !empty;
  assign rx_io.bk_data  = rd_beat.tdata;
  assign rx_io.bk_tstrb = rd_beat.tstrb;
  assign rx_io.bk_tkeep = rd_beat.tkeep;
  assign rx_io.bk_user  = rd_beat.tuser;
  assign rx_io.bk_tlast = rd_beat.tlast;

`ifdef AXIS_RX_PKT_CNT_EN
  logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

  // Null beats still close a packet.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (accept && rx_io.axis_tlast) pkt_cnt_d = pkt_cnt_q + 1'b1;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) pkt_cnt_q <= '0;
    else              pkt_cnt_q <= pkt_cnt_d;
  end

  assign rx_io.pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_s_rx.sv
// Directed bench for axis_s_rx: cycle table for backpressure and null beats,
// plus sequences for single beat, streaming, async reset and counter wrap.
module tb_axis_s_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  axis_s_rx_if #(.DEPTH(4), .TDATA_W(32), .TUSER_W(2)) bus ();

  axis_s_rx #(.DEPTH(4), .TDATA_W(32), .TUSER_W(2)) dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .rx_io       (bus)
  );

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        rdy;
    logic        e_trdy;
    logic        e_vld;
    logic [31:0] e_data;
    logic        e_last;
    logic [2:0]  e_lvl;
    logic [15:0] e_pkt;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic vld, input logic [31:0] data, input logic [3:0] keep,
                       input logic last, input logic rdy);
    bus.axis_tvalid = vld;
    bus.axis_tdata  = data;
    bus.axis_tstrb  = keep;
    bus.axis_tkeep  = keep;
    bus.axis_tlast  = last;
    bus.axis_tuser  = 2'd0;
    bus.bk_ready    = rdy;
  endtask

  task automatic chk_pkt(input string name, input logic [15:0] exp);
`ifdef AXIS_RX_PKT_CNT_EN
    chk(name, 32'(bus.pkt_cnt), 32'(exp));
`else
    if (exp === 16'hxxxx) $display("unused %s", name);
`endif
  endtask

  initial begin
    //          vld data       keep  last rdy  trdy vld e_data     e_last lvl  pkt
    tbl[0]  = '{1'b1, 32'h10, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 3'd1, 16'd1};
    tbl[1]  = '{1'b1, 32'h11, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 3'd2, 16'd1};
    tbl[2]  = '{1'b1, 32'h12, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b0, 3'd3, 16'd1};
    tbl[3]  = '{1'b1, 32'h13, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 3'd4, 16'd1};
    tbl[4]  = '{1'b1, 32'h14, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 3'd4, 16'd1};
    tbl[5]  = '{1'b1, 32'h14, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 3'd3, 16'd1};
    tbl[6]  = '{1'b1, 32'h14, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 32'h12, 1'b0, 3'd3, 16'd1};
    tbl[7]  = '{1'b1, 32'h15, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 32'h13, 1'b0, 3'd3, 16'd2};
    tbl[8]  = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 3'd2, 16'd2};
    tbl[9]  = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h15, 1'b1, 3'd1, 16'd2};
    tbl[10] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 3'd0, 16'd2};
    tbl[11] = '{1'b1, 32'h20, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 3'd1, 16'd2};
    tbl[12] = '{1'b1, 32'h21, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 3'd1, 16'd2};
    tbl[13] = '{1'b1, 32'h22, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 3'd2, 16'd3};
    tbl[14] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 1'b1, 3'd1, 16'd3};
    tbl[15] = '{1'b0, 32'h0,  4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 3'd0, 16'd3};
    tbl[16] = '{1'b1, 32'h23, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 3'd0, 16'd4};

    // Reset state
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_tready", 32'(bus.axis_tready), 32'd0);
    chk("rst_valid", 32'(bus.bk_valid), 32'd0);
    chk("rst_level", 32'(bus.fifo_level), 32'd0);
    chk("rst_data", bus.bk_data, 32'd0);
    chk_pkt("rst_pkt", 16'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_tready_low", 32'(bus.axis_tready), 32'd0);
    @(negedge clk);
    step();
    chk("rel_tready_high", 32'(bus.axis_tready), 32'd1);

    // Single beat, all fields
    drive(1'b1, 32'hA5A5_0001, 4'hF, 1'b1, 1'b1);
    bus.axis_tstrb = 4'hC;
    bus.axis_tuser = 2'd2;
    step();
    chk("sb_valid", 32'(bus.bk_valid), 32'd1);
    chk("sb_data", bus.bk_data, 32'hA5A5_0001);
    chk("sb_strb", 32'(bus.bk_tstrb), 32'hC);
    chk("sb_keep", 32'(bus.bk_tkeep), 32'hF);
    chk("sb_user", 32'(bus.bk_user), 32'd2);
    chk("sb_last", 32'(bus.bk_tlast), 32'd1);
    chk_pkt("sb_pkt", 16'd1);
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    step();
    chk("sb_drain_valid", 32'(bus.bk_valid), 32'd0);
    chk("sb_drain_level", 32'(bus.fifo_level), 32'd0);

    // Backpressure and null beats
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].vld, tbl[i].data, tbl[i].keep, tbl[i].last, tbl[i].rdy);
      step();
      chk($sformatf("tbl%0d_tready", i), 32'(bus.axis_tready), 32'(tbl[i].e_trdy));
      chk($sformatf("tbl%0d_valid", i), 32'(bus.bk_valid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_level", i), 32'(bus.fifo_level), 32'(tbl[i].e_lvl));
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d_data", i), bus.bk_data, tbl[i].e_data);
        chk($sformatf("tbl%0d_last", i), 32'(bus.bk_tlast), 32'(tbl[i].e_last));
      end
      chk_pkt($sformatf("tbl%0d_pkt", i), tbl[i].e_pkt);
    end

    // Full throughput: head after edge i is beat i
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 4'hF, 1'b0, 1'b1);
      step();
      chk($sformatf("tp%0d_tready", i), 32'(bus.axis_tready), 32'd1);
      chk($sformatf("tp%0d_level", i), 32'(bus.fifo_level), 32'd1);
      chk($sformatf("tp%0d_data", i), bus.bk_data, 32'h100 + 32'(i));
    end
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    step();
    chk("tp_drain_level", 32'(bus.fifo_level), 32'd0);
    chk_pkt("tp_pkt", 16'd4);

    // Reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40 + 32'(i), 4'hF, (i == 2), 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("mr_level_before", 32'(bus.fifo_level), 32'd3);
    chk_pkt("mr_pkt_before", 16'd5);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(bus.bk_valid), 32'd0);
    chk("mr_level", 32'(bus.fifo_level), 32'd0);
    chk("mr_tready", 32'(bus.axis_tready), 32'd0);
    chk_pkt("mr_pkt", 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mr_rel_tready", 32'(bus.axis_tready), 32'd1);
    drive(1'b1, 32'h30, 4'hF, 1'b1, 1'b1);
    step();
    chk("mr_new_valid", 32'(bus.bk_valid), 32'd1);
    chk("mr_new_data", bus.bk_data, 32'h30);
    chk_pkt("mr_new_pkt", 16'd1);

`ifdef AXIS_RX_PKT_CNT_EN
    // Counter wrap with null single-beat packets
    drive(1'b1, 32'h0, 4'h0, 1'b1, 1'b1);
    repeat (65533) @(posedge clk);
    step();
    chk_pkt("wrap_ffff", 16'hFFFF);
    step();
    chk_pkt("wrap_zero", 16'h0000);
    chk("wrap_level", 32'(bus.fifo_level), 32'd0);
`endif
    drive(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
